// File: rtl/uart_cmd_parser.sv
// Frames UART bytes (SYNC, ADDR, D3..D0, CSUM) into one-cycle register writes.
// Drops and counts bad frames, and returns to HUNT after an inter-byte timeout.
module uart_cmd_parser #(
  parameter int unsigned CLK_FREQ      = 25000000,
  parameter int unsigned BAUD_RATE     = 1000000,
  parameter int unsigned TIMEOUT_BYTES = 4,
  parameter int unsigned NUM_REGS      = 4,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        err_pulse,
  output logic [7:0]  err_count,
  output logic        busy
);

  // state | meaning
  // HUNT  | waiting for SYNC_BYTE, other bytes ignored
  // ADDR  | next byte is the register address
  // DATA  | collecting D3..D0 into the shadow word
  // CSUM  | next byte is the checksum, frame completes
  typedef enum logic [1:0] {HUNT, ADDR, DATA, CSUM} state_e;

  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  state_e        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    acc_q, acc_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_en_q, wr_en_d;
  logic          err_q, err_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          timeout;

  assign timeout = (state_q != HUNT) && !rx_valid && (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    wr_en_d   = 1'b0;
    err_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    tmo_d     = (rx_valid || state_q == HUNT) ? '0 : tmo_q + TW'(1);

    case (state_q)
      HUNT: if (rx_valid && rx_data == SYNC_BYTE) begin
        state_d = ADDR;
        acc_d   = 8'h00;
      end
      ADDR: if (rx_valid) begin
        addr_d  = rx_data;
        acc_d   = rx_data;
        idx_d   = 2'd0;
        state_d = DATA;
      end
      DATA: if (rx_valid) begin
        shadow_d = {shadow_q[23:0], rx_data};
        acc_d    = acc_q ^ rx_data;
        idx_d    = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = CSUM;
      end
      CSUM: if (rx_valid) begin
        state_d = HUNT;
        if (rx_data == acc_q && {1'b0, addr_q} < NUM_REGS_W) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = shadow_q;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase

    // timeout implies no byte this cycle, so the case above made no change
    if (timeout) begin
      state_d = HUNT;
      err_d   = 1'b1;
    end

    if (err_d && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      addr_q    <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      tmo_q     <= tmo_d;
      wr_en_q   <= wr_en_d;
      err_q     <= err_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign err_pulse = err_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign err_count = cnt_q;
  assign busy      = (state_q != HUNT);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed and random frames against a frame-level model of the command parser.
module tb_uart_cmd_parser;
  localparam int NUM_REGS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic        busy;

  uart_cmd_parser #(
    .CLK_FREQ(25000000), .BAUD_RATE(1000000), .TIMEOUT_BYTES(4),
    .NUM_REGS(NUM_REGS), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .err_pulse(err_pulse), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int wr_pulses = 0, err_pulses = 0, viol = 0;
  logic prev_wr = 1'b0, prev_err = 1'b0;

  // pulse bookkeeping, sampled on the falling edge
  always @(negedge clk) begin
    if (wr_en) wr_pulses++;
    if (err_pulse) err_pulses++;
    if ((wr_en && err_pulse) || (wr_en && prev_wr) || (err_pulse && prev_err)) viol++;
    prev_wr = wr_en;
    prev_err = err_pulse;
  end

  logic [7:0]  exp_addr = 8'h00;
  logic [31:0] exp_data = 32'h0;
  int          exp_cnt = 0;
  int          exp_wr = 0, exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // called one step after a rising edge; returns one step after the capturing edge
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  function automatic bit frame_ok(input logic [7:0] a, input logic [31:0] d, input logic [7:0] cs);
    logic [7:0] x;
    x = a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    return (cs == x) && (int'(a) < NUM_REGS);
  endfunction

  task automatic model_result(input bit ok, input logic [7:0] a, input logic [31:0] d);
    if (ok) begin
      exp_wr++;
      exp_addr = a;
      exp_data = d;
    end else begin
      exp_err++;
      if (exp_cnt < 255) exp_cnt++;
    end
  endtask

  task automatic check_frame_end(input string tag, input bit ok);
    chk({tag, ".wr_en"}, 32'(wr_en), 32'(ok));
    chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(!ok));
    chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(exp_addr));
    chk({tag, ".wr_data"}, wr_data, exp_data);
    chk({tag, ".err_count"}, 32'(err_count), 32'(exp_cnt));
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] a, input logic [31:0] d,
                            input logic [7:0] cs, input int gap);
    bit ok;
    send_byte(8'hA5); idle(gap);
    send_byte(a);     idle(gap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(d[8*i +: 8]);
      idle(gap);
    end
    send_byte(cs);
    ok = frame_ok(a, d, cs);
    model_result(ok, a, d);
    check_frame_end(tag, ok);
  endtask

  initial begin
    logic [7:0]  ra, rc;
    logic [31:0] rd;

    #2;
    chk("reset.wr_en", 32'(wr_en), 32'd0);
    chk("reset.err_pulse", 32'(err_pulse), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.wr_addr", 32'(wr_addr), 32'd0);
    chk("reset.wr_data", wr_data, 32'd0);
    chk("reset.err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // T1..T3
    send_frame("t1_good", 8'h01, 32'h12345678, 8'h09, 249);
    send_frame("t2_badcs", 8'h01, 32'h12345678, 8'h08, 3);
    send_frame("t3_badaddr", 8'h04, 32'h00000001, 8'h05, 3);
    send_frame("sync_as_data", 8'h03, 32'hA5A5A5A5, 8'h03, 1);

    // T4 timeout fires exactly TIMEOUT_CYCLES after the last byte
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
    idle(999);
    chk("t4_pre.busy", 32'(busy), 32'd1);
    chk("t4_pre.err_count", 32'(err_count), 32'(exp_cnt));
    idle(1);
    model_result(1'b0, 8'h00, 32'h0);
    chk("t4.err_pulse", 32'(err_pulse), 32'd1);
    chk("t4.busy", 32'(busy), 32'd0);
    chk("t4.err_count", 32'(err_count), 32'(exp_cnt));
    send_frame("t4_after", 8'h02, 32'h00000007, 8'h05, 2);

    // byte landing on the expiry cycle wins
    send_byte(8'hA5); send_byte(8'h03);
    idle(999);
    chk("expiry.busy", 32'(busy), 32'd1);
    send_byte(8'h00);
    chk("expiry_byte.busy", 32'(busy), 32'd1);
    chk("expiry_byte.err_pulse", 32'(err_pulse), 32'd0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h11); send_byte(8'h12);
    model_result(1'b1, 8'h03, 32'h00000011);
    check_frame_end("expiry_frame", 1'b1);

    // T5 noise then back-to-back frames
    send_byte(8'h00); send_byte(8'hFF);
    chk("t5_noise.busy", 32'(busy), 32'd0);
    send_frame("t5_a", 8'h00, 32'hDEADBEEF, 8'h00 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, 0);
    send_frame("t5_b", 8'h03, 32'hCAFE0123, 8'h03 ^ 8'hCA ^ 8'hFE ^ 8'h01 ^ 8'h23, 0);

    // random frames
    for (int n = 0; n < 24; n++) begin
      ra = 8'($urandom_range(0, 5));
      rd = $urandom;
      rc = ra ^ rd[31:24] ^ rd[23:16] ^ rd[15:8] ^ rd[7:0];
      if ($urandom_range(0, 3) == 0) rc = rc ^ 8'($urandom_range(1, 255));
      send_frame("rand", ra, rd, rc, $urandom_range(0, 300));
    end

    // T6 reset mid-frame, then saturate the error counter
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
    rst_n = 1'b0;
    #1;
    exp_addr = 8'h00; exp_data = 32'h0; exp_cnt = 0;
    chk("t6_rst.busy", 32'(busy), 32'd0);
    chk("t6_rst.wr_addr", 32'(wr_addr), 32'd0);
    chk("t6_rst.wr_data", wr_data, 32'd0);
    chk("t6_rst.err_count", 32'(err_count), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    chk("t6_post.err_count", 32'(err_count), 32'd0);
    chk("t6_post.err_pulse", 32'(err_pulse), 32'd0);
    for (int n = 0; n < 260; n++)
      send_frame("t6_bad", 8'h01, 32'h0000_0000 + 32'(n), 8'h01 ^ 8'(n) ^ 8'h80, 0);
    chk("t6.err_count_sat", 32'(err_count), 32'd255);

    idle(3);
    chk("total.wr_pulses", 32'(wr_pulses), 32'(exp_wr));
    chk("total.err_pulses", 32'(err_pulses), 32'(exp_err));
    chk("total.pulse_rules", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
